// File: rtl/fifo_drain_pkg.sv
// Shared types and sizes for the FIFO read-side drain stage.
package fifo_drain_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned BUF_DEPTH      = 2;
    localparam int unsigned CNT_W          = $clog2(BUF_DEPTH + 1);
    localparam int unsigned LVL_W          = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } drain_state_e;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry skid buffer: pop-then-push ordering, synchronous clear, head always at r_head.
module skid_buf2
    import fifo_drain_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [CNT_W-1:0]      o_count
);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [CNT_W-1:0]      r_count;

    // The push slot is chosen after the pop has shifted the tail forward.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_pop && i_push) begin
            if (r_count == CNT_W'(BUF_DEPTH)) begin
                r_head <= r_tail;
                r_tail <= i_data;
            end else begin
                r_head <= i_data;
            end
        end else if (i_pop) begin
            r_head  <= r_tail;
            r_count <= r_count - CNT_W'(1);
        end else if (i_push) begin
            if (r_count == '0) begin
                r_head <= i_data;
            end else begin
                r_tail <= i_data;
            end
            r_count <= r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !i_clear) begin
            assert (!(i_push && !i_pop && (r_count == CNT_W'(BUF_DEPTH))))
                else $error("skid_buf2: push into a full buffer");
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/fifo_stream_drain.sv
// Read-side consumer of the sync FIFO: issues rd_en, absorbs the 1-cycle read latency
// in a 2-entry skid buffer and presents a valid/ready stream with flush and status.
module fifo_stream_drain
    import fifo_drain_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  drained_cnt,
    output logic                  err_underflow
);

    drain_state_e          r_state;
    logic                  r_inflight;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_drained;

    logic [CNT_W-1:0]      w_count;
    logic [DATA_WIDTH-1:0] w_head;
    logic [LVL_W-1:0]      w_level;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_clear;
    logic                  w_rd_en;

    assign m_valid = (w_count != '0);
    assign m_data  = w_head;
    assign w_pop   = m_valid && m_ready;
    assign w_clear = flush || (r_state == FLUSH);
    assign w_push  = r_inflight && !w_clear;

    // Occupancy after this cycle, counting the word already requested from the FIFO.
    assign w_level = LVL_W'(w_count) + LVL_W'(r_inflight) - LVL_W'(w_pop);

    assign w_rd_en = !rst && (r_state != FLUSH) && !flush && !fifo_empty
                     && (w_level < LVL_W'(BUF_DEPTH));
    assign fifo_rd_en = w_rd_en;

    skid_buf2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (fifo_dout),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_inflight <= 1'b0;
            r_drained  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_pop) begin
                r_drained <= r_drained + CNT_WIDTH'(1);
            end
            if (fifo_underflow && r_inflight) begin
                r_err <= 1'b1;
            end
            if (flush) begin
                r_state <= FLUSH;
            end else begin
                case (r_state)
                    IDLE:    if (w_rd_en) r_state <= RUN;
                    RUN:     if ((w_level == '0) && !w_rd_en && fifo_empty) r_state <= IDLE;
                    FLUSH:   r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign drained_cnt   = r_drained;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed and randomized bench for fifo_stream_drain against a queue-based FIFO and stream model.
module tb_fifo_stream_drain;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_underflow;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          flush;
    logic [CW-1:0] drained_cnt;
    logic          err_underflow;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] pend[$];
    logic [DW-1:0] exp_q[$];
    int            fifo_cnt = 0;
    int unsigned   exp_cnt;
    int            rd_seen;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always #5 clk = ~clk;

    fifo_stream_drain #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_dout      (fifo_dout),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .flush          (flush),
        .drained_cnt    (drained_cnt),
        .err_underflow  (err_underflow)
    );

    // Sync FIFO with registered read data; newly loaded words become visible after one edge.
    assign fifo_empty = (fifo_cnt == 0);
    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() != 0) fifo_dout <= fq.pop_front();
        while (pend.size() != 0) fq.push_back(pend.pop_front());
        fifo_cnt <= fq.size();
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic load(input logic [DW-1:0] w);
        pend.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Stream monitor: ordered delivery, stall stability, and loss of unread data on flush/reset.
    always @(negedge clk) begin
        if (prev_stall) begin
            chk("hold_valid", 32'(m_valid), 32'(1));
            chk("hold_data", 32'(m_data), 32'(prev_data));
        end
        if (!rst && m_valid && m_ready) begin
            chk("scb_has_word", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) chk("data", 32'(m_data), 32'(exp_q.pop_front()));
        end
        if (rst || flush) begin
            exp_q = fq;
            foreach (pend[i]) exp_q.push_back(pend[i]);
        end
        prev_stall = !rst && !flush && m_valid && !m_ready;
        prev_data  = m_data;
    end

    initial begin
        rst = 1'b1; flush = 1'b0; m_ready = 1'b1; fifo_underflow = 1'b0; exp_cnt = 0;

        // Reset with a non-empty FIFO
        for (int i = 1; i <= 8; i++) load(DW'(i));
        drive_pt();
        smp();
        chk("rst_rd_en", 32'(fifo_rd_en), 32'(0));
        chk("rst_valid", 32'(m_valid), 32'(0));
        chk("rst_cnt", 32'(drained_cnt), 32'(0));
        chk("rst_err", 32'(err_underflow), 32'(0));
        drive_pt();
        rst = 1'b0;

        // Full-throughput streaming of 8 words
        for (int k = 0; k < 12; k++) begin
            smp();
            chk("stream_rd_en", 32'(fifo_rd_en), 32'(k < 8));
            chk("stream_valid", 32'(m_valid), 32'(k >= 2 && k < 10));
            drive_pt();
        end
        exp_cnt += 8;
        smp();
        chk("stream_cnt", 32'(drained_cnt), 32'(CW'(exp_cnt)));
        chk("stream_left", 32'(exp_q.size()), 32'(0));
        drive_pt();

        // Backpressure: only two reads may be outstanding against a stalled head
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) load(DW'(i));
        drive_pt();
        rd_seen = 0;
        for (int k = 0; k < 10; k++) begin
            smp();
            rd_seen += int'(fifo_rd_en);
            if (k >= 2) chk("bp_head", 32'(m_data), 32'(1));
            drive_pt();
        end
        chk("bp_reads", 32'(rd_seen), 32'(2));
        m_ready = 1'b1;
        repeat (14) drive_pt();
        exp_cnt += 8;
        smp();
        chk("bp_cnt_wrap", 32'(drained_cnt), 32'(CW'(exp_cnt)));
        chk("bp_left", 32'(exp_q.size()), 32'(0));
        drive_pt();

        // Flush with one word buffered and one in flight
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) load(DW'(16'hA0 + i));
        drive_pt();
        drive_pt();
        drive_pt();
        flush = 1'b1;
        smp();
        chk("fl_pre_valid", 32'(m_valid), 32'(1));
        chk("fl_rd_gate", 32'(fifo_rd_en), 32'(0));
        drive_pt();
        flush = 1'b0;
        smp();
        chk("fl_valid", 32'(m_valid), 32'(0));
        chk("fl_state_rd", 32'(fifo_rd_en), 32'(0));
        chk("fl_cnt", 32'(drained_cnt), 32'(CW'(exp_cnt)));
        drive_pt();
        smp();
        chk("fl_resume", 32'(fifo_rd_en), 32'(1));
        drive_pt();
        drive_pt();
        smp();
        chk("fl_next_word", 32'(m_data), 32'(16'hA3));
        drive_pt();
        m_ready = 1'b1;
        repeat (8) drive_pt();
        exp_cnt += 2;
        smp();
        chk("fl_cnt_after", 32'(drained_cnt), 32'(CW'(exp_cnt)));
        chk("fl_left", 32'(exp_q.size()), 32'(0));
        drive_pt();

        // Flush coinciding with a pop: the popped word still counts
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) load(DW'(16'hB0 + i));
        repeat (4) drive_pt();
        smp();
        chk("fp_head", 32'(m_data), 32'(16'hB1));
        drive_pt();
        m_ready = 1'b1;
        flush = 1'b1;
        drive_pt();
        flush = 1'b0;
        m_ready = 1'b0;
        exp_cnt += 1;
        smp();
        chk("fp_valid", 32'(m_valid), 32'(0));
        chk("fp_cnt", 32'(drained_cnt), 32'(CW'(exp_cnt)));
        drive_pt();
        m_ready = 1'b1;
        repeat (10) drive_pt();
        exp_cnt += 2;
        smp();
        chk("fp_cnt_after", 32'(drained_cnt), 32'(CW'(exp_cnt)));
        chk("fp_left", 32'(exp_q.size()), 32'(0));
        drive_pt();

        // Underflow while a read is in flight sets the sticky flag
        load(16'hC001);
        load(16'hC002);
        drive_pt();
        drive_pt();
        fifo_underflow = 1'b1;
        smp();
        chk("uf_before", 32'(err_underflow), 32'(0));
        drive_pt();
        fifo_underflow = 1'b0;
        smp();
        chk("uf_set", 32'(err_underflow), 32'(1));
        repeat (6) drive_pt();
        exp_cnt += 2;
        smp();
        chk("uf_sticky", 32'(err_underflow), 32'(1));
        chk("uf_cnt", 32'(drained_cnt), 32'(CW'(exp_cnt)));
        drive_pt();

        // Random loads and random backpressure
        for (int c = 0; c < 400; c++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                int n;
                n = int'($urandom_range(1, 3));
                for (int j = 0; j < n; j++) load(DW'($urandom));
                exp_cnt += n;
            end
            drive_pt();
        end
        m_ready = 1'b1;
        repeat (120) drive_pt();
        smp();
        chk("rnd_cnt", 32'(drained_cnt), 32'(CW'(exp_cnt)));
        chk("rnd_left", 32'(exp_q.size()), 32'(0));
        chk("rnd_idle", 32'(m_valid), 32'(0));
        drive_pt();

        // Reset in the middle of a transfer
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) load(DW'(16'hD0 + i));
        drive_pt();
        drive_pt();
        drive_pt();
        rst = 1'b1;
        drive_pt();
        rst = 1'b0;
        exp_cnt = 0;
        smp();
        chk("mr_valid", 32'(m_valid), 32'(0));
        chk("mr_cnt", 32'(drained_cnt), 32'(0));
        chk("mr_err", 32'(err_underflow), 32'(0));
        chk("mr_rd", 32'(fifo_rd_en), 32'(1));
        drive_pt();
        m_ready = 1'b1;
        repeat (10) drive_pt();
        exp_cnt += 2;
        smp();
        chk("mr_cnt_after", 32'(drained_cnt), 32'(CW'(exp_cnt)));
        chk("mr_left", 32'(exp_q.size()), 32'(0));
        drive_pt();

        // Counter wrap: 17 words into a 4-bit counter
        rst = 1'b1;
        drive_pt();
        rst = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 17; i++) load(DW'(16'hE000 + i));
        repeat (30) drive_pt();
        exp_cnt += 17;
        smp();
        chk("wrap_cnt", 32'(drained_cnt), 32'(CW'(exp_cnt)));
        chk("wrap_left", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
